// File: rtl/run_watchdog_pkg.sv
// Shared types and helpers for the run watchdog: FSM state encoding and
// counter sizing. Optional elapsed-tick output is enabled by RUN_WATCHDOG_ELAPSED_EN.
package run_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    EXPIRED  = 2'd2,
    FINISHED = 2'd3
  } wd_state_e;

  localparam int ELAPSED_W = 16;

  // Bits needed to hold every value from 0 up to and including limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/run_watchdog_tick_gen.sv
// Prescaler: divides clk down to one tick every CLK_PER_TICK enabled cycles.
// The tick is decoded from the count, so a clear on the wrap cycle still lets it out.
module tick_gen
  import run_watchdog_pkg::*;
#(
  parameter int CLK_PER_TICK = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = cnt_width(CLK_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CLK_PER_TICK - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/run_watchdog.sv
// Run watchdog: arms on start, expires after TIMEOUT_TICKS ticks without kick or done.
// Define RUN_WATCHDOG_ELAPSED_EN to add the saturating elapsed-tick output.
module run_watchdog
  import run_watchdog_pkg::*;
#(
  parameter int CLK_PER_TICK  = 100000,
  parameter int TIMEOUT_TICKS = 30,
  parameter int STEP_TICKS    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic kick,
  input  logic done,
  output logic running,
  output logic progress,
  output logic expired,
  output logic finished
`ifdef RUN_WATCHDOG_ELAPSED_EN
  ,
  output logic [ELAPSED_W-1:0] elapsed
`endif
);

  if (CLK_PER_TICK < 1) begin : g_bad_clk_per_tick
    $error("CLK_PER_TICK must be at least 1");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout_ticks
    $error("TIMEOUT_TICKS must be at least 1");
  end
  if (STEP_TICKS < 1) begin : g_bad_step_ticks
    $error("STEP_TICKS must be at least 1");
  end

  localparam int TW = cnt_width(TIMEOUT_TICKS);
  localparam int SW = cnt_width(STEP_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STEP_TICKS - 1);

  wd_state_e     state;
  wd_state_e     next_state;
  logic          tick;
  logic          prescale_clear;
  logic          in_run;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] step_cnt;

  assign in_run = (state == RUN);

  tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (prescale_clear),
    .enable(in_run),
    .tick  (tick)
  );

  // Priority inside RUN: start, then done, then kick, then expiry.
  always_comb begin
    next_state     = state;
    prescale_clear = 1'b0;
    case (state)
      RUN: begin
        if (start) begin
          prescale_clear = 1'b1;
        end else if (done) begin
          next_state = FINISHED;
        end else if (kick) begin
          prescale_clear = 1'b1;
        end else if (tick && (tick_cnt == T_LAST)) begin
          next_state = EXPIRED;
        end
      end
      default: begin
        if (start) begin
          next_state     = RUN;
          prescale_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
      expired  <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= next_state;
      running  <= (next_state == RUN);
      expired  <= (next_state == EXPIRED);
      finished <= (next_state == FINISHED);
    end
  end

  // Kick restarts the timeout window only; the progress cadence keeps counting ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      step_cnt <= '0;
      progress <= 1'b0;
    end else begin
      progress <= 1'b0;
      if (start) begin
        tick_cnt <= '0;
        step_cnt <= '0;
      end else if (in_run) begin
        if (kick) begin
          tick_cnt <= '0;
        end else if (tick) begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (tick) begin
          if (step_cnt == S_LAST) begin
            step_cnt <= '0;
            progress <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef RUN_WATCHDOG_ELAPSED_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      elapsed <= '0;
    end else if (in_run && tick && (elapsed != {ELAPSED_W{1'b1}})) begin
      elapsed <= elapsed + 1'b1;
    end
  end
`endif

endmodule
